// File: rtl/cache_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_cache
// Description : Shared encodings for the 4-way, 16-set, 32-byte-line cache:
//               datapath mux selects and the control FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_cache;

    // Way selects: 0 = way that matched the tag, 1 = LRU (victim) way
    typedef enum logic {
        DIRTYWMUX_HIT = 1'b0,
        DIRTYWMUX_LRU = 1'b1
    } dirtywmux_t;

    typedef enum logic {
        DATAWMUX_HIT = 1'b0,
        DATAWMUX_LRU = 1'b1
    } datawmux_t;

    typedef enum logic {
        PLRUWMUX_HIT = 1'b0,
        PLRUWMUX_LRU = 1'b1
    } plruwmux_t;

    // Data array write source: CPU wdata with byte enables, or a full refill line
    typedef enum logic {
        DATAMUX_CPU  = 1'b0,
        DATAMUX_PMEM = 1'b1
    } datamux_t;

    // CPU read data source: array output only
    typedef enum logic {
        MERDMUX_ARRAY = 1'b0
    } merdmux_t;

    // Physical-memory address: CPU tag (refill) or victim tag (writeback)
    typedef enum logic {
        PMADMUX_CPU    = 1'b0,
        PMADMUX_VICTIM = 1'b1
    } pmadmux_t;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_REFILL    = 3'd4
    } cache_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : cache_perf_counter
// Description : One saturating event counter; holds at all-ones, cleared only
//               by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_perf_counter #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    output logic [PERF_W-1:0] count_o
);

    logic [PERF_W-1:0] count_q;

    // Count enabled events, stop at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Sequencing FSM for the 4-way / 16-set / 32-byte-line cache.
//               Decides hit/miss, writes back dirty victims, refills the line
//               and replays the lookup. All datapath controls are decoded
//               combinationally from the state and the current inputs.
//               Optional performance counters: define CACHE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_control
    import pkg_cache::*;
#(
    parameter int unsigned PERF_W = 32
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic       SIGHIT,
    input  logic       SIGDIRTY,
    output logic       LD_VALID,
    output logic       LD_DIRTY,
    output logic       LD_TAG,
    output logic       LD_DATA,
    output logic       LD_PLRU,
    output logic       LD_TMPTAG,
    output logic       LD_TMPDATA,
    output logic       DIRTYVAL,
    output dirtywmux_t DIRTYWMUX,
    output datawmux_t  DATAWMUX,
    output plruwmux_t  PLRUWMUX,
    output datamux_t   DATAMUX,
    output merdmux_t   MERDMUX,
    output pmadmux_t   PMADMUX
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] hit_cnt,
    output logic [PERF_W-1:0] miss_cnt,
    output logic [PERF_W-1:0] wb_cnt
`endif
);

    cache_state_t state_q;
    cache_state_t state_d;
    logic         w_req;

    // An illegal read+write request is handled as a write
    assign w_req = mem_read | mem_write;

    // Temporary registers and the read-data merge path are unused
    assign LD_TMPTAG  = 1'b0;
    assign LD_TMPDATA = 1'b0;
    assign MERDMUX    = MERDMUX_ARRAY;

    // Next-state selection and datapath control decode
    always_comb begin
        state_d    = state_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        LD_VALID   = 1'b0;
        LD_DIRTY   = 1'b0;
        LD_TAG     = 1'b0;
        LD_DATA    = 1'b0;
        LD_PLRU    = 1'b0;
        DIRTYVAL   = 1'b0;
        DIRTYWMUX  = DIRTYWMUX_HIT;
        DATAWMUX   = DATAWMUX_HIT;
        PLRUWMUX   = PLRUWMUX_HIT;
        DATAMUX    = DATAMUX_CPU;
        PMADMUX    = PMADMUX_CPU;

        case (state_q)
            ST_IDLE: begin
                // One cycle for the synchronous SRAM read at the request index
                if (w_req) begin
                    state_d = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (!w_req) begin
                    state_d = ST_IDLE;
                end else if (SIGHIT) begin
                    mem_resp = 1'b1;
                    LD_PLRU  = 1'b1;
                    PLRUWMUX = PLRUWMUX_HIT;
                    if (mem_write) begin
                        LD_DATA   = 1'b1;
                        DATAWMUX  = DATAWMUX_HIT;
                        DATAMUX   = DATAMUX_CPU;
                        LD_DIRTY  = 1'b1;
                        DIRTYWMUX = DIRTYWMUX_HIT;
                        DIRTYVAL  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (SIGDIRTY) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end

            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                PMADMUX    = PMADMUX_VICTIM;
                if (pmem_resp) begin
                    // Victim is now clean in memory
                    LD_DIRTY  = 1'b1;
                    DIRTYWMUX = DIRTYWMUX_LRU;
                    DIRTYVAL  = 1'b0;
                    state_d   = ST_ALLOCATE;
                end
            end

            ST_ALLOCATE: begin
                pmem_read = 1'b1;
                PMADMUX   = PMADMUX_CPU;
                if (pmem_resp) begin
                    // Install the fetched line as valid and clean in the LRU way
                    LD_DATA   = 1'b1;
                    DATAWMUX  = DATAWMUX_LRU;
                    DATAMUX   = DATAMUX_PMEM;
                    LD_TAG    = 1'b1;
                    LD_VALID  = 1'b1;
                    LD_DIRTY  = 1'b1;
                    DIRTYWMUX = DIRTYWMUX_LRU;
                    DIRTYVAL  = 1'b0;
                    state_d   = ST_REFILL;
                end
            end

            ST_REFILL: begin
                // One cycle for the SRAM re-read; the replayed lookup then hits
                state_d = ST_LOOKUP;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic w_lookup;
    logic w_hit_evt;
    logic w_miss_evt;
    logic w_wb_evt;
    logic replay_q;
    logic replay_d;

    assign w_lookup   = (state_q == ST_LOOKUP);
    assign w_miss_evt = w_lookup & w_req & ~SIGHIT;
    assign w_hit_evt  = w_lookup & w_req & SIGHIT & ~replay_q;
    assign w_wb_evt   = (state_q == ST_WRITEBACK) & pmem_resp;

    // Replay flag: set by a miss, cleared when the next lookup resolves
    always_comb begin
        replay_d = replay_q;
        if (w_lookup) begin
            replay_d = w_miss_evt;
        end
    end

    // Replay flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_q <= 1'b0;
        end else begin
            replay_q <= replay_d;
        end
    end

    cache_perf_counter #(.PERF_W(PERF_W)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_hit_evt),
        .count_o (hit_cnt)
    );

    cache_perf_counter #(.PERF_W(PERF_W)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_miss_evt),
        .count_o (miss_cnt)
    );

    cache_perf_counter #(.PERF_W(PERF_W)) u_wb_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_wb_evt),
        .count_o (wb_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_control
// Description : Self-checking bench for cache_control. A transaction-level
//               cache model (tags, valid, dirty, true LRU) decides hit/miss
//               and victim dirtiness; each request is walked through its
//               expected phases and every cycle's controls are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control;
    import pkg_cache::*;

    localparam int PW = 8;

    // Expected-control bit positions in the observed vector
    localparam int B_RESP = 16, B_PRD = 15, B_PWR = 14, B_LDV = 13, B_LDD = 12;
    localparam int B_LDT  = 11, B_LDA = 10, B_LDP = 9, B_DV = 6;
    localparam int B_DWM  = 5, B_DAWM = 4, B_DM = 2, B_PM = 0;

    localparam logic [16:0] E_NONE    = 17'd0;
    localparam logic [16:0] E_RD_HIT  = (17'd1 << B_RESP) | (17'd1 << B_LDP);
    localparam logic [16:0] E_WR_HIT  = E_RD_HIT | (17'd1 << B_LDA) | (17'd1 << B_LDD) | (17'd1 << B_DV);
    localparam logic [16:0] E_WB_WAIT = (17'd1 << B_PWR) | (17'd1 << B_PM);
    localparam logic [16:0] E_WB_DONE = E_WB_WAIT | (17'd1 << B_LDD) | (17'd1 << B_DWM);
    localparam logic [16:0] E_AL_WAIT = (17'd1 << B_PRD);
    localparam logic [16:0] E_AL_DONE = E_AL_WAIT | (17'd1 << B_LDA) | (17'd1 << B_DAWM) | (17'd1 << B_DM)
                                        | (17'd1 << B_LDT) | (17'd1 << B_LDV) | (17'd1 << B_LDD) | (17'd1 << B_DWM);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0, SIGHIT = 1'b0, SIGDIRTY = 1'b0;
    logic mem_resp, pmem_read, pmem_write;
    logic LD_VALID, LD_DIRTY, LD_TAG, LD_DATA, LD_PLRU, LD_TMPTAG, LD_TMPDATA, DIRTYVAL;
    dirtywmux_t DIRTYWMUX;
    datawmux_t  DATAWMUX;
    plruwmux_t  PLRUWMUX;
    datamux_t   DATAMUX;
    merdmux_t   MERDMUX;
    pmadmux_t   PMADMUX;
`ifdef CACHE_PERF_CNT_EN
    logic [PW-1:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int m_hits = 0, m_miss = 0, m_wb = 0;

    // Cache contents model
    bit [3:0] m_tag   [16][4];
    bit       m_val   [16][4];
    bit       m_dirty [16][4];
    int       m_age   [16][4];

    always #5 clk = ~clk;

    cache_control #(.PERF_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .SIGHIT     (SIGHIT),
        .SIGDIRTY   (SIGDIRTY),
        .LD_VALID   (LD_VALID),
        .LD_DIRTY   (LD_DIRTY),
        .LD_TAG     (LD_TAG),
        .LD_DATA    (LD_DATA),
        .LD_PLRU    (LD_PLRU),
        .LD_TMPTAG  (LD_TMPTAG),
        .LD_TMPDATA (LD_TMPDATA),
        .DIRTYVAL   (DIRTYVAL),
        .DIRTYWMUX  (DIRTYWMUX),
        .DATAWMUX   (DATAWMUX),
        .PLRUWMUX   (PLRUWMUX),
        .DATAMUX    (DATAMUX),
        .MERDMUX    (MERDMUX),
        .PMADMUX    (PMADMUX)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
`endif
    );

    function automatic logic [16:0] obs();
        return {mem_resp, pmem_read, pmem_write, LD_VALID, LD_DIRTY, LD_TAG, LD_DATA, LD_PLRU,
                LD_TMPTAG, LD_TMPDATA, DIRTYVAL, DIRTYWMUX, DATAWMUX, PLRUWMUX, DATAMUX, MERDMUX, PMADMUX};
    endfunction

`ifdef CACHE_PERF_CNT_EN
    function automatic int sat(input int v);
        return (v > (2**PW - 1)) ? (2**PW - 1) : v;
    endfunction
`endif

    // Walk one CPU request through its expected phases; every cycle compared.
    // Phases: 0 issue, 1 first lookup, 2 writeback, 3 allocate, 4 refill, 5 replay, 6 done
    task automatic run_request(input string nm, input bit rd, input bit wr, input bit hit,
                               input bit dirty, input int wb_lat, input int al_lat);
        int ph = 0;
        int nxt;
        int cnt = 0;
        logic [16:0] exp_v;
        for (int c = 0; c < 64 && ph != 6; c++) begin
            mem_read  = rd;
            mem_write = wr;
            SIGHIT    = 1'($urandom_range(0, 1));
            SIGDIRTY  = 1'($urandom_range(0, 1));
            pmem_resp = 1'($urandom_range(0, 1));
            exp_v     = E_NONE;
            nxt       = ph;
            case (ph)
                0: begin
                    SIGHIT = 1'b1;
                    nxt    = 1;
                end
                1: begin
                    SIGHIT   = hit;
                    SIGDIRTY = dirty;
                    if (hit) begin
                        exp_v = wr ? E_WR_HIT : E_RD_HIT;
                        nxt   = 6;
                        m_hits++;
                    end else begin
                        nxt = dirty ? 2 : 3;
                        m_miss++;
                    end
                end
                2: begin
                    pmem_resp = (cnt == wb_lat);
                    exp_v     = pmem_resp ? E_WB_DONE : E_WB_WAIT;
                    cnt++;
                    if (pmem_resp) begin
                        nxt = 3;
                        cnt = 0;
                        m_wb++;
                    end
                end
                3: begin
                    pmem_resp = (cnt == al_lat);
                    exp_v     = pmem_resp ? E_AL_DONE : E_AL_WAIT;
                    cnt++;
                    if (pmem_resp) nxt = 4;
                end
                4: nxt = 5;
                default: begin
                    SIGHIT = 1'b1;
                    exp_v  = wr ? E_WR_HIT : E_RD_HIT;
                    nxt    = 6;
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (obs() !== exp_v)
                $display("FAIL %s phase%0d cyc%0d: controls got %h expected %h", nm, ph, c, obs(), exp_v);
            else
                n_pass++;
            @(posedge clk);
            #1;
            ph = nxt;
        end
        n_chk++;
        if (ph != 6)
            $display("FAIL %s timeout: phase got %0d expected 6", nm, ph);
        else
            n_pass++;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        SIGHIT    = 1'b0;
        SIGDIRTY  = 1'b0;
    endtask

    task automatic test_reset();
        mem_read  = 1'b1;
        SIGHIT    = 1'b1;
        pmem_resp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (obs() !== E_NONE) $display("FAIL reset_outputs: got %h expected %h", obs(), E_NONE);
        else n_pass++;
`ifdef CACHE_PERF_CNT_EN
        n_chk++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== '0)
            $display("FAIL reset_counters: got %h/%h/%h expected 0", hit_cnt, miss_cnt, wb_cnt);
        else n_pass++;
`endif
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        SIGHIT    = 1'b0;
        pmem_resp = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_withdraw();
        mem_read = 1'b1;
        SIGHIT   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs() !== E_NONE) $display("FAIL withdraw cyc%0d: got %h expected %h", c, obs(), E_NONE);
            else n_pass++;
            @(posedge clk);
            #1;
            mem_read = 1'b0;
        end
        SIGHIT = 1'b0;
    endtask

    task automatic test_stray_resp();
        for (int c = 0; c < 3; c++) begin
            pmem_resp = 1'b1;
            SIGDIRTY  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_chk++;
            if (obs() !== E_NONE) $display("FAIL stray_resp cyc%0d: got %h expected %h", c, obs(), E_NONE);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        pmem_resp = 1'b0;
        SIGDIRTY  = 1'b0;
        run_request("after_stray", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_miss();
        mem_read = 1'b1;
        SIGHIT   = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs() !== E_NONE) $display("FAIL rstmiss_issue: got %h expected %h", obs(), E_NONE);
        else n_pass++;
        @(posedge clk);
        #1;
        SIGHIT = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs() !== E_AL_WAIT) $display("FAIL rstmiss_alloc%0d: got %h expected %h", c, obs(), E_AL_WAIT);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if (obs() !== E_NONE) $display("FAIL rstmiss_async: got %h expected %h", obs(), E_NONE);
        else n_pass++;
        m_hits = 0;
        m_miss = 0;
        m_wb   = 0;
`ifdef CACHE_PERF_CNT_EN
        n_chk++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== '0)
            $display("FAIL rstmiss_counters: got %h/%h/%h expected 0", hit_cnt, miss_cnt, wb_cnt);
        else n_pass++;
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        // The line was never installed, so the same address misses again
        run_request("rstmiss_retry", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int  set  = $urandom_range(0, 15);
            bit [3:0] tag = 4'($urandom_range(0, 5));
            int  kind = $urandom_range(0, 9);
            bit  rd   = (kind != 0) && (kind < 6 || kind == 9);
            bit  wr   = (kind >= 6) || (kind == 0);
            int  way  = -1;
            int  vic  = 0;
            bit  hit;
            bit  dty;
            if (!rd && !wr) rd = 1'b1;
            for (int w = 0; w < 4; w++)
                if (m_val[set][w] && m_tag[set][w] == tag) way = w;
            hit = (way >= 0);
            if (!hit) begin
                vic = -1;
                for (int w = 3; w >= 0; w--)
                    if (!m_val[set][w]) vic = w;
                if (vic < 0) begin
                    vic = 0;
                    for (int w = 1; w < 4; w++)
                        if (m_age[set][w] > m_age[set][vic]) vic = w;
                end
                way = vic;
            end
            dty = !hit && m_val[set][vic] && m_dirty[set][vic];
            run_request($sformatf("rand%0d", i), rd, wr, hit, dty, $urandom_range(0, 4), $urandom_range(0, 4));
            if (!hit) begin
                m_tag[set][way]   = tag;
                m_val[set][way]   = 1'b1;
                m_dirty[set][way] = 1'b0;
            end
            if (wr) m_dirty[set][way] = 1'b1;
            for (int w = 0; w < 4; w++) m_age[set][w]++;
            m_age[set][way] = 0;
        end
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_counters();
        n_chk++;
        if (hit_cnt !== PW'(sat(m_hits))) $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, sat(m_hits));
        else n_pass++;
        n_chk++;
        if (miss_cnt !== PW'(sat(m_miss))) $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, sat(m_miss));
        else n_pass++;
        n_chk++;
        if (wb_cnt !== PW'(sat(m_wb))) $display("FAIL wb_cnt: got %0d expected %0d", wb_cnt, sat(m_wb));
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++)
            run_request("sat_hit", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        n_chk++;
        if (hit_cnt !== 8'd255) $display("FAIL hit_cnt_sat: got %0d expected 255", hit_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        run_request("read_miss_clean", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5);
        run_request("read_hit", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        run_request("write_hit", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_request("read_miss_dirty", 1'b1, 1'b0, 1'b0, 1'b1, 3, 2);
        run_request("write_miss_dirty", 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        run_request("illegal_rdwr_hit", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        run_request("illegal_rdwr_miss", 1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
`ifdef CACHE_PERF_CNT_EN
        test_counters();
`endif
        test_withdraw();
        test_stray_resp();
        test_reset_mid_miss();
        test_random(60);
`ifdef CACHE_PERF_CNT_EN
        test_counters();
        test_saturation();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
